// File: rtl/mmio_led_pkg.sv
// Shared constants for the LED MMIO responder: register map,
// responder FSM encoding and decoded window size.
package mmio_led_pkg;

    localparam int WINDOW_BITS = 8;

    localparam logic [7:0] OFS_LED_DATA  = 8'h00;
    localparam logic [7:0] OFS_LED_SET   = 8'h04;
    localparam logic [7:0] OFS_LED_CLR   = 8'h08;
    localparam logic [7:0] OFS_TICKS     = 8'h0C;
    localparam logic [7:0] OFS_CTRL      = 8'h10;
    localparam logic [7:0] OFS_BLINK_DIV = 8'h14;

    localparam logic [5:0] W_LED_DATA  = OFS_LED_DATA[7:2];
    localparam logic [5:0] W_LED_SET   = OFS_LED_SET[7:2];
    localparam logic [5:0] W_LED_CLR   = OFS_LED_CLR[7:2];
    localparam logic [5:0] W_TICKS     = OFS_TICKS[7:2];
    localparam logic [5:0] W_CTRL      = OFS_CTRL[7:2];
    localparam logic [5:0] W_BLINK_DIV = OFS_BLINK_DIV[7:2];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/mmio_led_responder_blink.sv
// Blink divider for the LED responder: a free-running divider that
// toggles a phase bit; only built when MMIO_LED_BLINK_EN is defined.
module led_blink_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [23:0] div,
    input  logic        restart,
    output logic        phase
);

    logic [23:0] cnt;

    // A restart clears the count but never cancels a toggle due on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else begin
            if (cnt == div) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 24'd1;
            end
            if (restart) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mmio_led_responder.sv
// PicoRV32 native-bus responder owning the LED, set/clear and tick registers.
// Define MMIO_LED_BLINK_EN to add the CTRL/BLINK_DIV blink feature.
module mmio_led_responder
    import mmio_led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [7:0]  LED_RESET   = 8'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  led
);

    localparam logic [3:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    state_t      state_nxt;
    logic        sel;
    logic        commit;
    logic        load_wait;
    logic [3:0]  wait_cnt;

    logic [5:0]  req_ofs;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [5:0]  cur_ofs;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        wr_lo;

    logic [7:0]  led_data;
    logic [31:0] ticks;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign sel = mem_valid &&
        (mem_addr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);

    // The request is held in IDLE by the initiator; afterwards the latched copy
    // is used so a dropped mem_valid during WAIT still commits the original.
    assign cur_ofs   = (state == ST_IDLE) ? mem_addr[7:2] : req_ofs;
    assign cur_wdata = (state == ST_IDLE) ? mem_wdata     : req_wdata;
    assign cur_wstrb = (state == ST_IDLE) ? mem_wstrb     : req_wstrb;
    assign wr_lo     = commit && cur_wstrb[0];

    assign unused_bits = ^{mem_addr[1:0], cur_wdata[31:8], cur_wstrb[3:1]};

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        load_wait = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sel) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        load_wait = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_ACK;
                    commit    = 1'b1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_wait) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_ofs   <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else if (state == ST_IDLE && sel) begin
            req_ofs   <= mem_addr[7:2];
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ticks <= '0;
        end else begin
            ticks <= ticks + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_data <= LED_RESET;
        end else if (wr_lo) begin
            case (cur_ofs)
                W_LED_DATA: led_data <= cur_wdata[7:0];
                W_LED_SET:  led_data <= led_data | cur_wdata[7:0];
                W_LED_CLR:  led_data <= led_data & ~cur_wdata[7:0];
                default:    led_data <= led_data;
            endcase
        end
    end

`ifdef MMIO_LED_BLINK_EN
    logic        blink_en;
    logic [23:0] blink_div;
    logic        blink_en_nxt;
    logic        div_wr;
    logic        phase;

    // The divider sees the post-write enable so disabling restores led at once.
    assign blink_en_nxt = (wr_lo && cur_ofs == W_CTRL) ?
        cur_wdata[0] : blink_en;
    assign div_wr = commit && (cur_ofs == W_BLINK_DIV) && (|cur_wstrb[2:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_en  <= 1'b0;
            blink_div <= '0;
        end else begin
            blink_en <= blink_en_nxt;
            if (commit && cur_ofs == W_BLINK_DIV) begin
                for (int i = 0; i < 3; i++) begin
                    if (cur_wstrb[i]) begin
                        blink_div[8*i +: 8] <= cur_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    led_blink_gen u_blink (
        .clk     (clk),
        .resetn  (resetn),
        .en      (blink_en_nxt),
        .div     (blink_div),
        .restart (div_wr),
        .phase   (phase)
    );

    assign led = led_data & {8{phase}};
`else
    assign led = led_data;
`endif

    always_comb begin
        rd_val = '0;
        case (cur_ofs)
            W_LED_DATA,
            W_LED_SET,
            W_LED_CLR:   rd_val = {24'h0, led_data};
            W_TICKS:     rd_val = ticks;
`ifdef MMIO_LED_BLINK_EN
            W_CTRL:      rd_val = {31'h0, blink_en};
            W_BLINK_DIV: rd_val = {8'h0, blink_div};
`else
            W_CTRL:      rd_val = '0;
            W_BLINK_DIV: rd_val = '0;
`endif
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_rdata <= '0;
        end else if (commit) begin
            mem_rdata <= rd_val;
        end else if (state == ST_ACK) begin
            mem_rdata <= '0;
        end
    end

    assign mem_ready = (state == ST_ACK);

endmodule
